mult_unit: RTL and testbench

- Implements the FU_MULT functional unit: the consumer of fu_data_t issued by the scoreboard/issue stage and the producer of fu_result_t returned to writeback.
- Executes MUL, MULH, MULHU, MULHSU, MULW with a fixed latency.
- Executes DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW with an iterative radix-2 non-restoring/restoring divider.
- Handles one operation at a time. Valid/ready handshake on both sides. Flushable.

---
 rtl/mult_unit.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_mult_unit.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// mult_unit: multiply/divide functional unit, one operation in flight.
// Multiplies complete after MUL_LATENCY cycles. Divides use a one-bit-per-cycle
// restoring divider on operand magnitudes. Divide-by-zero, signed overflow and
// unknown op codes complete one cycle after accept.
// Ports:
//   clk_i, rst_ni                     clock, synchronous active-low reset
//   flush_i                           abort in-flight op, drop held result
//   fu_valid_i/fu_ready_o/fu_data_i   issue side handshake + operation
//   result_valid_o/result_ready_i     writeback side handshake
//   fu_result_o                       index, rd, result, exception

package mult_unit_pkg;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned OP_W   = 5;

  typedef logic [OP_W-1:0] fu_op_t;

  localparam fu_op_t OP_MUL    = 5'd0;
  localparam fu_op_t OP_MULH   = 5'd1;
  localparam fu_op_t OP_MULHU  = 5'd2;
  localparam fu_op_t OP_MULHSU = 5'd3;
  localparam fu_op_t OP_MULW   = 5'd4;
  localparam fu_op_t OP_DIV    = 5'd5;
  localparam fu_op_t OP_DIVU   = 5'd6;
  localparam fu_op_t OP_DIVW   = 5'd7;
  localparam fu_op_t OP_DIVUW  = 5'd8;
  localparam fu_op_t OP_REM    = 5'd9;
  localparam fu_op_t OP_REMU   = 5'd10;
  localparam fu_op_t OP_REMW   = 5'd11;
  localparam fu_op_t OP_REMUW  = 5'd12;

  localparam logic [DATA_W-1:0] CAUSE_ILLEGAL_INSTR = 64'd2;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] cause;
    logic [DATA_W-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic [RD_W-1:0]   rd;
    fu_op_t            op;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] operand_c;
  } fu_data_t;

  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] result;
    exception_t        ex;
  } fu_result_t;
endpackage

module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       fu_valid_i,
  output logic       fu_ready_o,
  input  fu_data_t   fu_data_i,
  output logic       result_valid_o,
  input  logic       result_ready_i,
  output fu_result_t fu_result_o
);

  localparam int unsigned CNT_W  = 7;
  localparam int unsigned PROD_W = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [RD_W-1:0]    rd_q, rd_d;
  fu_op_t             op_q, op_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic [XLEN-1:0]    rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic               is_w_q, is_w_d, is_rem_q, is_rem_d, valid_q, valid_d;
  exception_t         ex_q, ex_d;

  // Incoming operation decode
  fu_op_t          op_in;
  logic [XLEN-1:0] a_in, b_in, a_sext32, b_sext32, a_ext, b_ext, a_mag, b_mag;
  logic [XLEN-1:0] min_val, spec_res;
  logic            in_mul, in_div, div_signed, div_w, div_rem;
  logic            a_neg, b_neg, div_zero, div_ovf;

  assign op_in      = fu_data_i.op;
  assign a_in       = fu_data_i.operand_a;
  assign b_in       = fu_data_i.operand_b;
  assign in_mul     = op_in inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_MULW};
  assign in_div     = op_in inside {OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW,
                                    OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  assign div_signed = op_in inside {OP_DIV, OP_DIVW, OP_REM, OP_REMW};
  assign div_w      = op_in inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  assign div_rem    = op_in inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};

  // Word ops see only the low 32 bits, extended per signedness
  assign a_sext32 = {{(XLEN-32){a_in[31]}}, a_in[31:0]};
  assign b_sext32 = {{(XLEN-32){b_in[31]}}, b_in[31:0]};
  assign a_ext    = div_w ? (div_signed ? a_sext32 : {{(XLEN-32){1'b0}}, a_in[31:0]}) : a_in;
  assign b_ext    = div_w ? (div_signed ? b_sext32 : {{(XLEN-32){1'b0}}, b_in[31:0]}) : b_in;
  assign a_neg    = div_signed & a_ext[XLEN-1];
  assign b_neg    = div_signed & b_ext[XLEN-1];
  assign a_mag    = a_neg ? -a_ext : a_ext;
  assign b_mag    = b_neg ? -b_ext : b_ext;

  assign min_val  = div_w ? {{(XLEN-32){1'b1}}, 1'b1, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (b_ext == '0);
  assign div_ovf  = div_signed & (a_ext == min_val) & (b_ext == '1);

  // Zero divisor: q=all ones, r=dividend. Overflow: q=dividend, r=0.
  assign spec_res = div_zero ? (div_rem ? (div_w ? a_sext32 : a_in) : '1)
                             : (div_rem ? '0 : a_ext);

  // Single 65x65 signed multiplier covers all signedness combinations
  logic                   mul_a_signed, mul_b_signed;
  logic signed [XLEN:0]   mul_a, mul_b;
  logic signed [PROD_W+1:0] prod_full;
  logic [PROD_W-1:0]      prod_in;

  assign mul_a_signed = op_in inside {OP_MULH, OP_MULHSU};
  assign mul_b_signed = (op_in == OP_MULH);
  assign mul_a        = {mul_a_signed & a_in[XLEN-1], a_in};
  assign mul_b        = {mul_b_signed & b_in[XLEN-1], b_in};
  assign prod_full    = mul_a * mul_b;
  assign prod_in      = prod_full[PROD_W-1:0];

  function automatic logic [XLEN-1:0] mul_sel(input fu_op_t op, input logic [PROD_W-1:0] p);
    case (op)
      OP_MUL:  mul_sel = p[XLEN-1:0];
      OP_MULW: mul_sel = {{(XLEN-32){p[31]}}, p[31:0]};
      default: mul_sel = p[PROD_W-1:XLEN];
    endcase
  endfunction

  // Restoring divide step: shift in next dividend bit, subtract if it fits
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_nxt, quo_nxt, quo_fix, rem_fix, div_sel, div_res;

  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};
  assign q_bit    = ~rem_diff[XLEN];
  assign rem_nxt  = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nxt  = {quo_q[XLEN-2:0], q_bit};
  assign quo_fix  = neg_quo_q ? -quo_nxt : quo_nxt;
  assign rem_fix  = neg_rem_q ? -rem_nxt : rem_nxt;
  assign div_sel  = is_rem_q ? rem_fix : quo_fix;
  assign div_res  = is_w_q ? {{(XLEN-32){div_sel[31]}}, div_sel[31:0]} : div_sel;

  logic unused_bits;
  assign unused_bits = ^{fu_data_i.operand_c, prod_full[PROD_W+1:PROD_W]};

  assign fu_ready_o     = rst_ni & (state_q == IDLE) & ~flush_i;
  assign result_valid_o = valid_q;
  assign fu_result_o    = '{index: index_q, rd: rd_q, result: res_q, ex: ex_q};

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    rd_d      = rd_q;
    op_d      = op_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_w_d    = is_w_q;
    is_rem_d  = is_rem_q;
    valid_d   = valid_q;
    ex_d      = ex_q;

    case (state_q)
      IDLE: begin
        if (fu_valid_i && fu_ready_o) begin
          index_d = fu_data_i.index;
          rd_d    = fu_data_i.rd;
          op_d    = op_in;
          ex_d    = '0;
          if (in_mul) begin
            if (MUL_LATENCY == 1) begin
              res_d   = mul_sel(op_in, prod_in);
              valid_d = 1'b1;
              state_d = DONE;
            end else begin
              prod_d  = prod_in;
              state_d = MUL;
            end
          end else if (in_div) begin
            if (div_zero || div_ovf) begin
              res_d   = spec_res;
              valid_d = 1'b1;
              state_d = DONE;
            end else begin
              rem_d     = '0;
              // Word dividends sit in the top half so their MSB shifts out first
              quo_d     = div_w ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
              dvs_d     = b_mag;
              cnt_d     = div_w ? CNT_W'(32) : CNT_W'(64);
              neg_quo_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              is_w_d    = div_w;
              is_rem_d  = div_rem;
              state_d   = DIV;
            end
          end else begin
            res_d      = '0;
            ex_d.valid = 1'b1;
            ex_d.cause = CAUSE_ILLEGAL_INSTR;
            ex_d.tval  = '0;
            valid_d    = 1'b1;
            state_d    = DONE;
          end
        end
      end
      MUL: begin
        res_d   = mul_sel(op_q, prod_q);
        valid_d = 1'b1;
        state_d = DONE;
      end
      DIV: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_d   = div_res;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides accept and consume alike
    if (flush_i) begin
      state_d   = IDLE;
      index_d   = '0;
      rd_d      = '0;
      op_d      = '0;
      prod_d    = '0;
      rem_d     = '0;
      quo_d     = '0;
      dvs_d     = '0;
      res_d     = '0;
      cnt_d     = '0;
      neg_quo_d = 1'b0;
      neg_rem_d = 1'b0;
      is_w_d    = 1'b0;
      is_rem_d  = 1'b0;
      valid_d   = 1'b0;
      ex_d      = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      index_q   <= '0;
      rd_q      <= '0;
      op_q      <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_w_q    <= 1'b0;
      is_rem_q  <= 1'b0;
      valid_q   <= 1'b0;
      ex_q      <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      rd_q      <= rd_d;
      op_q      <= op_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_w_q    <= is_w_d;
      is_rem_q  <= is_rem_d;
      valid_q   <= valid_d;
      ex_q      <= ex_d;
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Bench for mult_unit: directed corner table, randomized ops against an
// arithmetic reference model, flush, backpressure, back-to-back and reset.
module tb_mult_unit;
  import mult_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic       fu_valid_i;
  logic       fu_ready_o;
  fu_data_t   fu_data_i;
  logic       result_valid_o;
  logic       result_ready_i;
  fu_result_t fu_result_o;

  int n_vec = 0;
  int n_err = 0;

  mult_unit #(.XLEN(64), .MUL_LATENCY(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .fu_valid_i    (fu_valid_i),
    .fu_ready_o    (fu_ready_o),
    .fu_data_i     (fu_data_i),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .fu_result_o   (fu_result_o)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the architectural rules
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_result(input fu_op_t op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb;
    logic [127:0]        ua, ub, p;
    logic signed [63:0]  sa64, sb64, sq;
    logic [31:0]         a32, b32, w;
    logic signed [31:0]  sa32, sb32, sw;
    sa = {{64{a[63]}}, a};  sb = {{64{b[63]}}, b};
    ua = {64'd0, a};        ub = {64'd0, b};
    sa64 = a; sb64 = b;
    a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    case (op)
      OP_MUL:    begin p = ua * ub; return p[63:0]; end
      OP_MULH:   begin p = sa * sb; return p[127:64]; end
      OP_MULHU:  begin p = ua * ub; return p[127:64]; end
      OP_MULHSU: begin p = sa * ub; return p[127:64]; end
      OP_MULW:   begin w = a32 * b32; return sx32(w); end
      OP_DIV: begin
        if (b == 0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        sq = sa64 / sb64; return sq;
      end
      OP_DIVU:   return (b == 0) ? '1 : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return '0;
        sq = sa64 % sb64; return sq;
      end
      OP_REMU:   return (b == 0) ? a : a % b;
      OP_DIVW: begin
        if (b32 == 0) return '1;
        if (a32 == 32'h8000_0000 && b32 == '1) return sx32(a32);
        sw = sa32 / sb32; return sx32(sw);
      end
      OP_DIVUW: begin
        if (b32 == 0) return '1;
        w = a32 / b32; return sx32(w);
      end
      OP_REMW: begin
        if (b32 == 0) return sx32(a32);
        if (a32 == 32'h8000_0000 && b32 == '1) return '0;
        sw = sa32 % sb32; return sx32(sw);
      end
      OP_REMUW: begin
        if (b32 == 0) return sx32(a32);
        w = a32 % b32; return sx32(w);
      end
      default:   return '0;
    endcase
  endfunction

  function automatic int ref_lat(input fu_op_t op, input logic [63:0] a, input logic [63:0] b);
    logic is_w, sgn;
    if (op <= OP_MULW) return 2;
    if (op > OP_REMUW) return 1;
    is_w = (op == OP_DIVW) || (op == OP_DIVUW) || (op == OP_REMW) || (op == OP_REMUW);
    sgn  = (op == OP_DIV) || (op == OP_DIVW) || (op == OP_REM) || (op == OP_REMW);
    if (is_w) begin
      if (b[31:0] == 0) return 1;
      if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 1;
      return 33;
    end
    if (b == 0) return 1;
    if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 65;
  endfunction

  function automatic exception_t ref_ex(input fu_op_t op);
    exception_t e;
    e = '0;
    if (op > OP_REMUW) begin
      e.valid = 1'b1;
      e.cause = 64'd2;
    end
    return e;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return {$urandom(), $urandom()};
      1: return 64'($urandom_range(0, 200));
      2: return '0;
      3: return '1;
      4: return 64'h8000_0000_0000_0000;
      5: return 64'hFFFF_FFFF_8000_0000;
      6: return -64'($urandom_range(1, 50));
      default: return {$urandom(), 32'h0};
    endcase
  endfunction

  // Issue one op and wait for result_valid_o; lat counts edges from accept (-1 on timeout)
  task automatic issue(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] idx, input logic [4:0] rd,
                       output int lat, output fu_result_t res);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!fu_ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    fu_data_i.op        = op;
    fu_data_i.operand_a = a;
    fu_data_i.operand_b = b;
    fu_data_i.operand_c = {$urandom(), $urandom()};
    fu_data_i.index     = idx;
    fu_data_i.rd        = rd;
    fu_valid_i          = 1'b1;
    @(posedge clk);
    #1 fu_valid_i = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!result_valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!result_valid_o) lat = -1;
    res = fu_result_o;
  endtask

  task automatic consume();
    result_ready_i = 1'b1;
    @(posedge clk);
    #1 result_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (fu_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", fu_ready_o); end
    n_vec++;
    if (result_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", result_valid_o); end
    n_vec++;
    if (fu_result_o !== '0) begin n_err++; $display("FAIL reset_result got=%h exp=0", fu_result_o); end
    rst_ni = 1'b1;
    @(negedge clk);
    n_vec++;
    if (fu_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got=%b exp=1", fu_ready_o); end
  endtask

  typedef struct {
    fu_op_t      op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } dir_t;

  task automatic test_directed();
    dir_t       tab [17];
    int         lat;
    fu_result_t r;
    exception_t ee;
    tab = '{
      '{OP_MUL,    64'd7,                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 2},
      '{OP_MULHU,  '1,                    '1,                      64'hFFFF_FFFF_FFFF_FFFE, 2},
      '{OP_MULW,   64'h7FFF_FFFF,         64'd2,                   64'hFFFF_FFFF_FFFF_FFFE, 2},
      '{OP_MULHSU, '1,                    64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 2},
      '{OP_DIV,    64'd100,               64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65},
      '{OP_REM,    64'd100,               64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   65},
      '{OP_DIVUW,  64'hFFFF_FFFF,         64'd1,                   64'hFFFF_FFFF_FFFF_FFFF, 33},
      '{OP_DIVU,   64'd1234,              64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 1},
      '{OP_REM,    64'd9,                 64'd0,                   64'd9,                   1},
      '{OP_DIVW,   64'h8000_0000,         '1,                      64'hFFFF_FFFF_8000_0000, 1},
      '{OP_REMW,   64'h8000_0000,         '1,                      64'd0,                   1},
      '{OP_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 2},
      '{OP_DIVW,   64'd7,                 64'h1_0000_0000,         64'hFFFF_FFFF_FFFF_FFFF, 1},
      '{OP_REMUW,  64'hFFFF_FFFF_8000_0005, 64'h1_0000_0000,       64'hFFFF_FFFF_8000_0005, 1},
      '{OP_DIV,    64'h8000_0000_0000_0000, '1,                    64'h8000_0000_0000_0000, 1},
      '{OP_REMW,   64'hFFFF_FFF9,         64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 33},
      '{5'd20,     64'd55,                64'd66,                  64'd0,                   1}
    };
    for (int i = 0; i < 17; i++) begin
      issue(tab[i].op, tab[i].a, tab[i].b, 4'(i + 5), 5'(i + 10), lat, r);
      ee = '0;
      if (i == 16) begin ee.valid = 1'b1; ee.cause = 64'd2; end
      n_vec++;
      if (lat !== tab[i].lat) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, tab[i].lat); end
      n_vec++;
      if (r.result !== tab[i].exp) begin n_err++; $display("FAIL dir%0d_result got=%h exp=%h", i, r.result, tab[i].exp); end
      n_vec++;
      if (r.ex !== ee) begin n_err++; $display("FAIL dir%0d_ex got=%h exp=%h", i, r.ex, ee); end
      n_vec++;
      if (r.index !== 4'(i + 5) || r.rd !== 5'(i + 10)) begin
        n_err++; $display("FAIL dir%0d_tag got=%0d/%0d exp=%0d/%0d", i, r.index, r.rd, i + 5, i + 10);
      end
      consume();
    end
  endtask

  task automatic test_random();
    fu_op_t      op;
    logic [63:0] a, b, exp;
    logic [3:0]  idx;
    logic [4:0]  rd;
    int          lat;
    fu_result_t  r;
    for (int i = 0; i < 40; i++) begin
      op  = fu_op_t'($urandom_range(0, 15));
      a   = pick_operand();
      b   = pick_operand();
      idx = 4'($urandom());
      rd  = 5'($urandom());
      exp = ref_result(op, a, b);
      issue(op, a, b, idx, rd, lat, r);
      n_vec++;
      if (lat !== ref_lat(op, a, b)) begin n_err++; $display("FAIL rnd%0d_latency op=%0d got=%0d exp=%0d", i, op, lat, ref_lat(op, a, b)); end
      n_vec++;
      if (r.result !== exp) begin n_err++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, r.result, exp); end
      n_vec++;
      if (r.ex !== ref_ex(op)) begin n_err++; $display("FAIL rnd%0d_ex op=%0d got=%h exp=%h", i, op, r.ex, ref_ex(op)); end
      n_vec++;
      if (r.index !== idx || r.rd !== rd) begin n_err++; $display("FAIL rnd%0d_tag got=%0d/%0d exp=%0d/%0d", i, r.index, r.rd, idx, rd); end
      consume();
    end
  endtask

  task automatic test_flush();
    int         lat;
    int         rose;
    fu_result_t r;
    @(negedge clk);
    fu_data_i.op = OP_DIV; fu_data_i.operand_a = 64'd1000; fu_data_i.operand_b = 64'd3;
    fu_data_i.index = 4'd2; fu_data_i.rd = 5'd3;
    fu_valid_i = 1'b1;
    @(posedge clk);
    #1 fu_valid_i = 1'b0;
    rose = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (result_valid_o) rose = 1;
    end
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rose !== 0 || result_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_no_valid got=%0d/%b exp=0/0", rose, result_valid_o); end
    n_vec++;
    if (fu_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready got=%b exp=1", fu_ready_o); end
    repeat (70) begin
      @(negedge clk);
      if (result_valid_o) rose = 1;
    end
    n_vec++;
    if (rose !== 0) begin n_err++; $display("FAIL flush_late_valid got=%0d exp=0", rose); end
    issue(OP_MUL, 64'd123456789, 64'd1000, 4'd9, 5'd17, lat, r);
    n_vec++;
    if (lat !== 2 || r.result !== 64'd123456789000) begin n_err++; $display("FAIL flush_next_mul got=%0d/%h exp=2/%h", lat, r.result, 64'd123456789000); end
    // Flush beats a simultaneous consume
    flush_i = 1'b1;
    result_ready_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0; result_ready_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (result_valid_o !== 1'b0 || fu_result_o !== '0) begin n_err++; $display("FAIL flush_done got=%b/%h exp=0/0", result_valid_o, fu_result_o); end
    // Flush beats a simultaneous offer
    fu_data_i.op = OP_MUL; fu_data_i.operand_a = 64'd5; fu_data_i.operand_b = 64'd6;
    fu_valid_i = 1'b1;
    flush_i = 1'b1;
    #1;
    n_vec++;
    if (fu_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_ready_low got=%b exp=0", fu_ready_o); end
    @(posedge clk);
    #1 fu_valid_i = 1'b0; flush_i = 1'b0;
    rose = 0;
    repeat (4) begin
      @(negedge clk);
      if (result_valid_o) rose = 1;
    end
    n_vec++;
    if (rose !== 0) begin n_err++; $display("FAIL flush_vs_accept got=%0d exp=0", rose); end
  endtask

  task automatic test_backpressure();
    int         lat;
    int         bad;
    fu_result_t r;
    issue(OP_MULHU, 64'hDEAD_BEEF_0000_0001, 64'h1_0000_0000, 4'd6, 5'd21, lat, r);
    n_vec++;
    if (r.result !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL bp_result got=%h exp=%h", r.result, 64'hDEAD_BEEF); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (fu_result_o !== r || result_valid_o !== 1'b1 || fu_ready_o !== 1'b0) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
    result_ready_i = 1'b1;
    n_vec++;
    if (fu_ready_o !== 1'b0 || fu_result_o !== r) begin n_err++; $display("FAIL bp_consume_cycle got=%b exp=0", fu_ready_o); end
    @(posedge clk);
    #1 result_ready_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (result_valid_o !== 1'b0 || fu_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_after got=%b/%b exp=0/1", result_valid_o, fu_ready_o); end
  endtask

  task automatic test_back_to_back();
    int         lat;
    fu_result_t r;
    issue(OP_MUL, 64'd11, 64'd13, 4'd1, 5'd1, lat, r);
    // Offer the next op in the consume cycle; it must not be taken yet
    fu_data_i.op = OP_MULW; fu_data_i.operand_a = 64'hFFFF_FFFF; fu_data_i.operand_b = 64'hFFFF_FFFF;
    fu_data_i.index = 4'd12; fu_data_i.rd = 5'd30;
    fu_valid_i = 1'b1;
    result_ready_i = 1'b1;
    n_vec++;
    if (fu_ready_o !== 1'b0 || r.result !== 64'd143) begin n_err++; $display("FAIL b2b_first got=%b/%h exp=0/%h", fu_ready_o, r.result, 64'd143); end
    @(posedge clk);
    #1 result_ready_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (fu_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", fu_ready_o); end
    @(posedge clk);
    #1 fu_valid_i = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!result_valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat !== 2 || fu_result_o.result !== 64'd1 || fu_result_o.index !== 4'd12 || fu_result_o.rd !== 5'd30) begin
      n_err++; $display("FAIL b2b_second got=%0d/%h exp=2/1", lat, fu_result_o.result);
    end
    consume();
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    fu_data_i.op = OP_DIVU; fu_data_i.operand_a = '1; fu_data_i.operand_b = 64'd7;
    fu_data_i.index = 4'd15; fu_data_i.rd = 5'd31;
    fu_valid_i = 1'b1;
    @(posedge clk);
    #1 fu_valid_i = 1'b0;
    repeat (20) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (fu_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready got=%b exp=0", fu_ready_o); end
    @(posedge clk);
    #1;
    n_vec++;
    if (result_valid_o !== 1'b0 || fu_result_o !== '0) begin n_err++; $display("FAIL rst_mid_outputs got=%b/%h exp=0/0", result_valid_o, fu_result_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    n_vec++;
    if (fu_ready_o !== 1'b1 || result_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle got=%b/%b exp=1/0", fu_ready_o, result_valid_o); end
  endtask

  initial begin
    rst_ni         = 1'b0;
    flush_i        = 1'b0;
    fu_valid_i     = 1'b0;
    result_ready_i = 1'b0;
    fu_data_i      = '0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
